// File: rtl/taller_keys_pio.sv
// Debounced active-low key PIO on an Avalon-MM slave: DATA, IRQMASK and a press EDGECAPTURE register.
// Debounce adds DEBOUNCE_CYCLES+2 clocks; reads have a fixed 1-cycle latency; irq lags EDGECAPTURE&IRQMASK by 1 cycle.
module taller_keys_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ec_q, ec_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] ec_clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:WIDTH];

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_en  = chipselect && !write_n;
    rd_en  = chipselect && !read_n;
    // Only falling debounced edges (key press) are captured.
    press  = deb_q & ~deb_d;
    ec_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    ec_d   = (ec_q & ~ec_clr) | press;
    mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = deb_q;
      2'd2:    rd_mux[WIDTH-1:0] = mask_q;
      2'd3:    rd_mux[WIDTH-1:0] = ec_q;
      default: rd_mux = '0;
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
    irq_d      = |(ec_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      mask_q     <= '0;
      ec_q       <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      mask_q     <= mask_d;
      ec_q       <= ec_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_taller_keys_pio.sv
// Directed bench for taller_keys_pio with WIDTH=4, DEBOUNCE_CYCLES=4; inputs change and outputs are sampled on falling edges.
module tb_taller_keys_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int fails  = 0;
  logic [31:0] rv;

  taller_keys_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    idle_bus();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    tick();
    idle_bus();
    d = readdata;
  endtask

  initial begin
    reset = 1'b1; in_port = 4'hF; address = 2'd0; writedata = '0;
    idle_bus();
    tick(3);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    rd(2'd0, rv); chk("data_after_reset", rv, 32'h0000000F);
    chk("irq_after_reset", {31'b0, irq}, 32'h0);
    rd(2'd1, rv); chk("reserved_reads_0", rv, 32'h0);
    rd(2'd3, rv); chk("ec_after_reset", rv, 32'h0);

    // Continuous DATA read: readdata shows the debounced value one edge late,
    // so a change on edge 6 appears at sample 7.
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    in_port = 4'hE;
    tick(6);
    chk("data_bit0_before_6", readdata, 32'h0000000F);
    tick();
    chk("data_bit0_after_6", readdata, 32'h0000000E);
    idle_bus();
    rd(2'd3, rv); chk("ec_press_bit0", rv, 32'h1);
    chk("irq_masked", {31'b0, irq}, 32'h0);

    wr(2'd2, 32'hFFFF_FFF1);
    chk("irq_same_edge_as_mask", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_after_mask", {31'b0, irq}, 32'h1);
    rd(2'd2, rv); chk("mask_upper_ignored", rv, 32'h1);

    wr(2'd3, 32'h1);
    chk("irq_same_edge_as_clear", {31'b0, irq}, 32'h1);
    tick();
    chk("irq_after_clear", {31'b0, irq}, 32'h0);
    rd(2'd3, rv); chk("ec_cleared", rv, 32'h0);

    wr(2'd0, 32'h0);
    rd(2'd0, rv); chk("data_write_ignored", rv, 32'h0000000E);

    in_port = 4'hF;
    tick(8);
    rd(2'd0, rv); chk("data_released", rv, 32'h0000000F);
    rd(2'd3, rv); chk("release_no_capture", rv, 32'h0);

    in_port = 4'hB;
    tick(3);
    in_port = 4'hF;
    tick(10);
    rd(2'd0, rv); chk("glitch_data", rv, 32'h0000000F);
    rd(2'd3, rv); chk("glitch_ec", rv, 32'h0);

    // Read of EDGECAPTURE on the capture edge returns the old value.
    in_port = 4'hE;
    tick(5);
    rd(2'd3, rv); chk("ec_read_on_set_edge", rv, 32'h0);
    rd(2'd3, rv); chk("ec_after_set_edge", rv, 32'h1);
    chk("irq_from_press", {31'b0, irq}, 32'h1);

    // Clear bit0 on the same edge bit1 is captured.
    in_port = 4'hF;
    tick(8);
    in_port = 4'hD;
    tick(5);
    wr(2'd3, 32'h1);
    rd(2'd3, rv); chk("clear_other_bit", rv, 32'h2);
    chk("irq_after_bit0_clear", {31'b0, irq}, 32'h0);

    // Clear and set of bit1 on the same edge: set wins.
    in_port = 4'hF;
    tick(8);
    in_port = 4'hD;
    tick(5);
    wr(2'd3, 32'h2);
    rd(2'd3, rv); chk("set_wins", rv, 32'h2);

    // Illegal read+write: write applies, readdata gets the pre-edge value.
    address = 2'd3; writedata = 32'h2; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
    tick();
    idle_bus();
    chk("rw_readdata_pre_edge", readdata, 32'h2);
    rd(2'd3, rv); chk("rw_write_applied", rv, 32'h0);

    in_port = 4'hF;
    tick(8);
    rd(2'd2, rv); chk("mask_before_reset", rv, 32'h1);

    // Press bit3, reset after the count reaches 2, then release reset with the key still held.
    in_port = 4'h7;
    tick(4);
    reset = 1'b1;
    tick(2);
    chk("reset_clears_readdata", readdata, 32'h0);
    reset = 1'b0;
    address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("no_early_set_%0d", k), readdata, 32'h0);
    end
    tick();
    chk("set_after_reset", readdata, 32'h8);
    idle_bus();
    rd(2'd2, rv); chk("mask_cleared_by_reset", rv, 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
